pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline hazard controller for the 5-stage core. It generates the pause and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles four cases: data-memory wait stalls, multi-cycle divide stalls, taken-branch flushes and load-use bubbles. It also keeps stall and flush performance counters.

## Interface
- DIV_CYCLES, 32, divider latency in cycles; must be ≥ 1
- CNT_W, 32, width of the performance counters
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs1_addr, id_rs2_addr  in  5 each  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1 each  the source is actually read
- ex_is_load  in  1  the instruction in EX is a load
- ex_rd_addr  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  branch or jump resolved taken in EX
- ex_div_start  in  1  the instruction in EX is a divide or remainder
- mem_req  in  1  the instruction in MEM accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_pause  out  1  hold the PC
- if_id_pause, if_id_flush  out  1 each
- id_ex_pause, id_ex_flush  out  1 each
- ex_mem_pause, ex_mem_flush  out  1 each
- mem_wb_flush  out  1  insert a bubble into MEM/WB
- div_go  out  1  one-cycle start pulse to the divider
- div_busy  out  1  controller is in the DIV state
- stall_cnt  out  CNT_W  number of cycles with pc_pause high
- flush_cnt  out  CNT_W  number of taken-branch flushes

## Operation
- The pipeline registers give flush priority over pause. For any one register, the controller never asserts pause and flush together.
- Control outputs are combinational from the state and the inputs. While rst_n is low, every pause, flush and div_go output is 0.
- Condition definitions:
  - mem_stall = mem_req & ~mem_ready
  - load_use = ex_is_load & (ex_rd_addr≠0) & ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr))
- Priority, highest first:
  1. mem_stall: pc, if_id, id_ex and ex_mem pause; mem_wb_flush. Nothing else is asserted.
  2. Divide stall. It applies in RUN when ex_div_start is high, or in DIV when cnt≠0. Pc, if_id and id_ex pause; ex_mem_flush.
  3. ex_branch_taken: if_id_flush and id_ex_flush. The PC is not paused, because the fetch redirect is taken elsewhere.
  4. load_use: pc and if_id pause; id_ex_flush.
  5. Otherwise all controls are 0.
- FSM states: RUN (the reset state) and DIV. A CNT_W-independent down-counter cnt, sized to hold DIV_CYCLES−1, resets to 0.
  - In RUN, if ex_div_start & ~mem_stall: div_go=1, cnt←DIV_CYCLES−1, next state DIV.
  - In DIV: cnt decrements each cycle and saturates at 0, even during mem_stall.
  - In DIV, when cnt==0 and ~mem_stall: no divide stall is applied and the next state is RUN. The divide result advances into EX/MEM on this edge.
  - In DIV, when cnt==0 and mem_stall: stay in DIV.
- div_busy = (state==DIV).
- stall_cnt increments on each cycle where pc_pause=1. flush_cnt increments on each cycle where the taken-branch flush (priority 3) is applied. Both saturate at all-ones.
- Asynchronous reset mid-operation: state becomes RUN, cnt 0, both counters 0, all outputs 0 immediately.

## Timing
- A divide stays in EX for exactly DIV_CYCLES+1 cycles when there is no memory stall:
  - one RUN detection cycle with pause and div_go,
  - DIV_CYCLES−1 DIV cycles with pause,
  - one final DIV cycle with cnt==0 and no pause.
- The divide adds DIV_CYCLES stall cycles. With DIV_CYCLES=1, only the detection cycle pauses.
- A load-use hazard costs one bubble. The dependent instruction leaves ID one cycle later.
- A taken branch costs two squashed instructions (IF/ID and ID/EX) and has zero pause.
- If mem_stall arrives during a branch or load-use cycle, the branch or load-use flush is suppressed. The condition is re-evaluated once the pipeline is released.

## Test plan
- Load-use: ex_is_load=1, ex_rd_addr=5, id_rs1_addr=5, id_rs1_used=1 for one cycle. Required: pc_pause=if_id_pause=id_ex_flush=1 for 1 cycle, then stall_cnt=1. With ex_rd_addr=0, no stall.
- Taken branch together with load-use in the same cycle: only if_id_flush=id_ex_flush=1, pc_pause=0, flush_cnt=1.
- Divide with DIV_CYCLES=4: ex_div_start held high. Required: div_go pulses once; pause is high for 4 cycles; div_busy is high for 4 cycles; the state returns to RUN on the 5th edge; stall_cnt=4.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1. Required: pc, if_id, id_ex and ex_mem pause plus mem_wb_flush for 3 cycles, all 0 in the 4th cycle.
- Memory stall inside a divide (DIV_CYCLES=2): mem_stall for 5 cycles starting in the DIV cycle with cnt=1. Required: stay in DIV with cnt=0 until mem_ready, then exit. ex_mem_flush never coincides with ex_mem_pause.
- Async reset: drop rst_n in mid-DIV with stall_cnt=7. Required: all outputs, cnt and counters 0 at once. After release the state is RUN and div_go=0 until a new ex_div_start.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard inputs and pause/flush controls between the core and pipe_ctrl
// master = pipeline side (drives hazard info), slave = pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             ex_is_load;
  logic [4:0]       ex_rd_addr;
  logic             ex_branch_taken;
  logic             ex_div_start;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_pause;
  logic             if_id_pause;
  logic             if_id_flush;
  logic             id_ex_pause;
  logic             id_ex_flush;
  logic             ex_mem_pause;
  logic             ex_mem_flush;
  logic             mem_wb_flush;
  logic             div_go;
  logic             div_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    output ex_is_load, ex_rd_addr, ex_branch_taken, ex_div_start,
    output mem_req, mem_ready,
    input  pc_pause, if_id_pause, if_id_flush, id_ex_pause, id_ex_flush,
    input  ex_mem_pause, ex_mem_flush, mem_wb_flush, div_go, div_busy,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    input  ex_is_load, ex_rd_addr, ex_branch_taken, ex_div_start,
    input  mem_req, mem_ready,
    output pc_pause, if_id_pause, if_id_flush, id_ex_pause, id_ex_flush,
    output ex_mem_pause, ex_mem_flush, mem_wb_flush, div_go, div_busy,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage pipeline hazard controller: memory-wait, divide, branch and load-use
// Pause/flush controls are combinational from state and inputs; stall/flush counters saturate.
module pipe_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    RUN = 1'b0,
    DIV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_stall;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic div_stall;
  logic branch_flush;

  logic pc_pause;
  logic if_id_pause;
  logic if_id_flush;
  logic id_ex_pause;
  logic id_ex_flush;
  logic ex_mem_pause;
  logic ex_mem_flush;
  logic mem_wb_flush;
  logic div_go;

  always_comb begin
    mem_stall = bus.mem_req & ~bus.mem_ready;
    rs1_hit   = bus.id_rs1_used & (bus.id_rs1_addr == bus.ex_rd_addr);
    rs2_hit   = bus.id_rs2_used & (bus.id_rs2_addr == bus.ex_rd_addr);
    load_use  = bus.ex_is_load & (bus.ex_rd_addr != 5'd0) & (rs1_hit | rs2_hit);
    // The last DIV cycle (cnt==0) lets the result advance, so it is not a stall.
    div_stall = ((state_q == RUN) & bus.ex_div_start) |
                ((state_q == DIV) & (cnt_q != '0));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      RUN: begin
        if (bus.ex_div_start && !mem_stall) begin
          state_d = DIV;
          cnt_d   = CNT_LOAD;
        end
      end
      DIV: begin
        // The divider keeps counting down even while memory holds the pipe.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
        if (cnt_q == '0 && !mem_stall) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pc_pause     = 1'b0;
    if_id_pause  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_pause  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_pause = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    div_go       = 1'b0;
    branch_flush = 1'b0;

    if (rst_n) begin
      if (mem_stall) begin
        pc_pause     = 1'b1;
        if_id_pause  = 1'b1;
        id_ex_pause  = 1'b1;
        ex_mem_pause = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (div_stall) begin
        pc_pause     = 1'b1;
        if_id_pause  = 1'b1;
        id_ex_pause  = 1'b1;
        ex_mem_flush = 1'b1;
        div_go       = (state_q == RUN);
      end else if (bus.ex_branch_taken) begin
        // Fetch redirect happens elsewhere; the PC keeps moving.
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        branch_flush = 1'b1;
      end else if (load_use) begin
        pc_pause     = 1'b1;
        if_id_pause  = 1'b1;
        id_ex_flush  = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_pause && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (branch_flush && flush_cnt_q != CNT_MAX) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_pause     = pc_pause;
  assign bus.if_id_pause  = if_id_pause;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_pause  = id_ex_pause;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_pause = ex_mem_pause;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.div_go       = div_go;
  assign bus.div_busy     = (state_q == DIV);
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule
